peripheral_reg_arbiter: RTL and testbench
=========================================

# peripheral_reg_arbiter

Two-requester round-robin arbiter and access sequencer for the peripheral register bank. Sits between two bus masters (CPU bus adapter on port 0, DMA/aux engine on port 1) and the register adapter side of the peripheral register map. It converts each granted request into one-cycle `write_en`/`read_en` strobes and returns registered read data, so FIFO pops and counter writes are never duplicated or lost.

## Interface
- `REGS`, 5, number of mapped registers.
- `ADDR_W`, `$clog2(REGS)` = 3, register address width.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 2: per-requester access request; bit k = requester k.
- `we` in 2: 1 = write, 0 = read.
- `lock` in 2: hold-ownership request; used only with the lock build option.
- `addr` in 2*ADDR_W: requester k at `[k*ADDR_W +: ADDR_W]`.
- `wdata` in 64: requester k at `[k*32 +: 32]`.
- `gnt` out 2: one-cycle pulse, request accepted.
- `ack` out 2: one-cycle pulse, access complete.
- `err` out 2: valid with `ack`; 1 = address ≥ REGS.
- `rdata` out 32: read data, valid with `ack` for reads.
- `write_en` out REGS: one-hot register write strobe.
- `read_en` out REGS: one-hot register read strobe.
- `data_in` out 32: register write data.
- `data_out` in REGS*32: register read data; register r at `[r*32 +: 32]`.

## Operation
- States: IDLE, ACCESS, RESP.
  - IDLE → ACCESS when any `req` is high.
  - ACCESS → RESP unconditionally.
  - RESP → ACCESS if any eligible `req` is high; otherwise RESP → IDLE.
- Arbitration happens on entry to ACCESS. Winner index, `we`, `addr` and `wdata` are latched into the `owner`/`cmd` registers.
- Priority pointer `prio`:
  - Reset value 0.
  - When only one requester is high, it wins.
  - When both are high, requester `prio` wins.
  - After each grant, `prio` = the requester that lost (the other index).
- ACCESS cycle:
  - `gnt[owner]` = 1.
  - If address < REGS: `write_en[addr]` = we, `read_en[addr]` = ~we.
  - `data_in` = latched wdata.
  - `data_out[addr]` is captured into the `rdata` register in this same cycle. FIFO reads therefore return the head before the pop.
- RESP cycle:
  - `ack[owner]` = 1.
  - `rdata` = captured value for reads, 0 for writes.
  - `err[owner]` = (addr ≥ REGS).
  - An out-of-range access asserts no strobes and returns `rdata` = 0.
- Requesters hold `req`, `we`, `addr` and `wdata` stable until `gnt`. A requester that keeps `req` high after `gnt` is re-arbitrated as a new request in RESP.
- Outside ACCESS, all of `write_en`, `read_en` and `gnt` are 0. Outside RESP, `ack` and `err` are 0.

## Timing
- Reset values: state IDLE, `prio` 0, lock owner none, `gnt`/`ack`/`err` 0, `write_en`/`read_en` 0, `data_in` 0, `rdata` 0.
- Latency:
  - `req` seen high at edge N (state IDLE) → ACCESS in cycle N+1 (`gnt` + strobe).
  - → RESP in cycle N+2 (`ack`).
- Back-to-back throughput: one access per 2 cycles (alternating ACCESS/RESP).
- Both requesters high continuously: grants alternate 0, 1, 0, 1 ...
- `reset` asserted mid-ACCESS or mid-RESP:
  - Next cycle is IDLE with all strobes low.
  - The pending `ack` is dropped; the requester must re-request.
- `req` dropped before `gnt`: the request is not served. Such a drop is illegal while in ACCESS, and the latched command completes anyway.

## Configuration
- `PERIPH_ARB_LOCK_EN` defined:
  - If `lock[owner]` = 1 during RESP, that requester becomes lock owner.
  - Only the lock owner is eligible for arbitration, and `prio` does not rotate.
  - If the owner has no `req`, the FSM idles without granting the other requester.
  - Ownership is released in the first cycle `lock[owner]` = 0 while the FSM is in IDLE or RESP.
  - Purpose: supports atomic read-modify-write of the config register.
- `PERIPH_ARB_LOCK_EN` undefined: `lock` is ignored and pure round-robin applies.

## Test plan
- Reset, then requester 0 writes 0x0000_0005 to addr 1 → `gnt[0]` at N+1 with `write_en` = 5'b00010 and `data_in` = 5; `ack[0]` at N+2, `err` 0.
- Requester 1 reads addr 4 with `data_out[4]` = 0x3C → `read_en` = 5'b10000 for exactly one cycle; `ack[1]` with `rdata` = 0x3C.
- Both requesters request continuously for 8 accesses → grant order 0,1,0,1,0,1,0,1; no cycle has two strobes set.
- Requester 0 reads addr 6 → no strobes asserted; `ack[0]` with `err[0]` = 1 and `rdata` = 0.
- `reset` asserted in the ACCESS cycle of a read → no `ack` follows; state IDLE and all outputs 0 on the next cycle.
- With `PERIPH_ARB_LOCK_EN` defined:
  - Requester 0 holds `lock` across read addr 1 / write addr 1 while requester 1 requests → requester 1 is not granted until `lock[0]` falls.
  - Requester 1 is then granted next.

Source files
------------

// File: rtl/peripheral_reg_arbiter.sv
// peripheral_reg_arbiter
// Two-requester round-robin arbiter and access sequencer for the peripheral
// register bank. Each granted request becomes exactly one ACCESS cycle that
// carries a one-hot write_en/read_en strobe. It is followed by one RESP cycle
// that returns ack/err/rdata.
//
// Build option: define PERIPH_ARB_LOCK_EN to enable ownership locking, which
// supports atomic read-modify-write sequences. When it is undefined, lock is
// ignored and arbitration is pure round-robin.
module peripheral_reg_arbiter #(
  parameter int REGS   = 5,
  parameter int ADDR_W = $clog2(REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [1:0]            lock,
  input  logic [2*ADDR_W-1:0]   addr,
  input  logic [63:0]           wdata,
  output logic [1:0]            gnt,
  output logic [1:0]            ack,
  output logic [1:0]            err,
  output logic [31:0]           rdata,
  output logic [REGS-1:0]       write_en,
  output logic [REGS-1:0]       read_en,
  output logic [31:0]           data_in,
  input  logic [REGS*32-1:0]    data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state;
  logic                prio;
  logic                owner_p0;
  logic                cmd_we_p0;
  logic [ADDR_W-1:0]   cmd_addr_p0;

  logic [1:0]          elig;
  logic                win;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [31:0]         sel_wdata;
  logic [REGS-1:0]     sel_dec;
  logic [REGS-1:0]     cmd_dec;
  logic                lock_hold;

  // One-hot register decode; an out-of-range address decodes to all zeros.
  function automatic logic [REGS-1:0] decode(input logic [ADDR_W-1:0] a);
    logic [REGS-1:0] d;
    d = '0;
    for (int r = 0; r < REGS; r++) begin
      if (a == ADDR_W'(r)) d[r] = 1'b1;
    end
    return d;
  endfunction

  // Read-data mux over the register bank; out-of-range returns zero.
  function automatic logic [31:0] rd_sel(input logic [ADDR_W-1:0] a,
                                         input logic [REGS*32-1:0] bank);
    logic [31:0] v;
    v = '0;
    for (int r = 0; r < REGS; r++) begin
      if (a == ADDR_W'(r)) v = bank[r*32 +: 32];
    end
    return v;
  endfunction

  // Winner selection: a lone requester wins, and a tie goes to prio.
  function automatic logic pick(input logic [1:0] e, input logic p);
    if (e == 2'b11) return p;
    return e[1];
  endfunction

`ifdef PERIPH_ARB_LOCK_EN
  logic lock_vld;
  logic lock_owner;
  logic lock_owner_nx;

  // Lock ownership for the next cycle. A RESP cycle samples the owner's lock
  // bit. An IDLE cycle releases the lock as soon as the owner drops it.
  always_comb begin
    lock_hold     = lock_vld;
    lock_owner_nx = lock_owner;
    if (state == RESP) begin
      lock_hold     = lock[owner_p0];
      lock_owner_nx = owner_p0;
    end else if (state == IDLE && lock_vld && !lock[lock_owner]) begin
      lock_hold = 1'b0;
    end
  end

  // Register the lock ownership.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_vld   <= 1'b0;
      lock_owner <= 1'b0;
    end else begin
      lock_vld   <= lock_hold;
      lock_owner <= lock_owner_nx;
    end
  end

  // While locked, only the owner may be arbitrated.
  always_comb begin
    elig = req;
    if (lock_hold) elig = req & (lock_owner_nx ? 2'b10 : 2'b01);
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock;

  // Without the lock option, every requester is always eligible.
  always_comb begin
    lock_hold = 1'b0;
    elig      = req;
  end
`endif

  // Select the winner's command fields for latching on entry to ACCESS.
  always_comb begin
    win       = pick(elig, prio);
    sel_we    = win ? we[1] : we[0];
    sel_addr  = win ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
    sel_wdata = win ? wdata[63:32] : wdata[31:0];
    sel_dec   = decode(sel_addr);
    cmd_dec   = decode(cmd_addr_p0);
  end

  // Access sequencer FSM with registered strobes and responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      prio        <= 1'b0;
      owner_p0    <= 1'b0;
      cmd_we_p0   <= 1'b0;
      cmd_addr_p0 <= '0;
      gnt         <= '0;
      ack         <= '0;
      err         <= '0;
      write_en    <= '0;
      read_en     <= '0;
      data_in     <= '0;
      rdata       <= '0;
    end else begin
      gnt      <= '0;
      ack      <= '0;
      err      <= '0;
      write_en <= '0;
      read_en  <= '0;
      case (state)
        IDLE, RESP: begin
          // Stage p0: arbitrate and latch the command for the ACCESS cycle.
          if (|elig) begin
            state       <= ACCESS;
            owner_p0    <= win;
            cmd_we_p0   <= sel_we;
            cmd_addr_p0 <= sel_addr;
            data_in     <= sel_wdata;
            gnt         <= win ? 2'b10 : 2'b01;
            write_en    <= sel_we ? sel_dec : '0;
            read_en     <= sel_we ? '0 : sel_dec;
            if (!lock_hold) prio <= ~win;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          // Stage p1: capture read data before any pop takes effect, then respond.
          state <= RESP;
          ack   <= owner_p0 ? 2'b10 : 2'b01;
          if (~|cmd_dec) err <= owner_p0 ? 2'b10 : 2'b01;
          rdata <= (cmd_we_p0 || ~|cmd_dec) ? 32'h0 : rd_sel(cmd_addr_p0, data_out);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_reg_arbiter.sv
// Testbench for peripheral_reg_arbiter: table-driven single accesses,
// round-robin alternation, reset during ACCESS and, under
// PERIPH_ARB_LOCK_EN, lock ownership. Responses are checked against a queue
// of expected results.
module tb_peripheral_reg_arbiter;
  localparam int REGS   = 5;
  localparam int ADDR_W = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          req, we, lock;
  logic [2*ADDR_W-1:0] addr;
  logic [63:0]         wdata;
  logic [1:0]          gnt, ack, err;
  logic [31:0]         rdata;
  logic [REGS-1:0]     write_en, read_en;
  logic [31:0]         data_in;
  logic [REGS*32-1:0]  data_out;

  always #5 clk = ~clk;

  assign data_out = {32'h0000_003C, 32'h0F0F_0F0F, 32'h1234_5678,
                     32'hA5A5_A5A5, 32'h1111_1111};

  peripheral_reg_arbiter #(.REGS(REGS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .lock(lock),
    .addr(addr), .wdata(wdata), .gnt(gnt), .ack(ack), .err(err),
    .rdata(rdata), .write_en(write_en), .read_en(read_en),
    .data_in(data_in), .data_out(data_out)
  );

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        port;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [4:0]  wen;
    logic [4:0]  ren;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[9];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] port_mask(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

  // Response monitor: every ack must match the oldest expected response.
  always @(negedge clk) begin
    if (ack !== 2'b00) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", {62'b0, ack}, 64'h0);
      end else begin
        mon_e = sb.pop_front();
        check("ack_port", {62'b0, ack}, {62'b0, port_mask(mon_e.port)});
        check("ack_err", {62'b0, err}, mon_e.err ? {62'b0, port_mask(mon_e.port)} : 64'h0);
        check("ack_rdata", {32'b0, rdata}, {32'b0, mon_e.rdata});
      end
    end
  end

  task automatic drive_cmd(input logic p, input logic w, input logic [2:0] a, input logic [31:0] d);
    int k;
    k = p ? 1 : 0;
    req[k] = 1'b1;
    we[k]  = w;
    addr[k*ADDR_W +: ADDR_W] = a;
    wdata[k*32 +: 32] = d;
  endtask

  task automatic wait_gnt(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (gnt == 2'b00 && cyc < 12);
  endtask

  task automatic do_access(input vec_t v);
    int cyc;
    drive_cmd(v.port, v.we, v.addr, v.wdata);
    sb.push_back('{port: v.port, err: v.err, rdata: v.rdata});
    wait_gnt(cyc);
    check("gnt", {62'b0, gnt}, {62'b0, port_mask(v.port)});
    check("gnt_latency", 64'(cyc), 64'd1);
    check("write_en", {59'b0, write_en}, {59'b0, v.wen});
    check("read_en", {59'b0, read_en}, {59'b0, v.ren});
    check("data_in", {32'b0, data_in}, {32'b0, v.wdata});
    req = 2'b00;
    @(negedge clk);
    check("resp_quiet", {52'b0, gnt, write_en, read_en}, 64'h0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 2'b00;
    lock  = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int ng;
    logic nexp;

    vecs[0] = '{1'b0, 1'b1, 3'd1, 32'h0000_0005, 5'b00010, 5'b00000, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 3'd4, 32'h0000_0000, 5'b00000, 5'b10000, 1'b0, 32'h0000_003C};
    vecs[2] = '{1'b0, 1'b0, 3'd6, 32'h0000_0000, 5'b00000, 5'b00000, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 3'd0, 32'hDEAD_BEEF, 5'b00001, 5'b00000, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 3'd2, 32'h0000_0077, 5'b00000, 5'b00100, 1'b0, 32'h1234_5678};
    vecs[5] = '{1'b1, 1'b0, 3'd5, 32'h0000_0000, 5'b00000, 5'b00000, 1'b1, 32'h0};
    vecs[6] = '{1'b0, 1'b1, 3'd5, 32'h0000_00AA, 5'b00000, 5'b00000, 1'b1, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 3'd7, 32'h0000_0000, 5'b00000, 5'b00000, 1'b1, 32'h0};
    vecs[8] = '{1'b0, 1'b0, 3'd0, 32'h0000_0000, 5'b00000, 5'b00001, 1'b0, 32'h1111_1111};

    reset = 1'b1;
    req   = 2'b00;
    we    = 2'b00;
    lock  = 2'b00;
    addr  = '0;
    wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt_ack_err", {58'b0, gnt, ack, err}, 64'h0);
    check("rst_strobes", {54'b0, write_en, read_en}, 64'h0);
    check("rst_data_in", {32'b0, data_in}, 64'h0);
    check("rst_rdata", {32'b0, rdata}, 64'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) do_access(vecs[i]);

    // Reset asserted during the ACCESS cycle of a read drops the response.
    drive_cmd(1'b0, 1'b0, 3'd2, 32'h0000_0099);
    wait_gnt(cyc);
    check("rst_mid_gnt", {62'b0, gnt}, 64'h1);
    check("rst_mid_read_en", {59'b0, read_en}, 64'h4);
    reset = 1'b1;
    req   = 2'b00;
    @(negedge clk);
    check("rst_mid_ctl", {58'b0, gnt, ack, err}, 64'h0);
    check("rst_mid_strobes", {54'b0, write_en, read_en}, 64'h0);
    check("rst_mid_data", {data_in, rdata}, 64'h0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_mid_no_ack", {62'b0, ack}, 64'h0);
    end

    // Both requesters held high: grants alternate starting with port 0.
    do_reset();
    drive_cmd(1'b0, 1'b0, 3'd1, 32'h0);
    drive_cmd(1'b1, 1'b0, 3'd3, 32'h0);
    ng   = 0;
    cyc  = 0;
    nexp = 1'b0;
    while (ng < 8 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      check("one_strobe", 64'($countones({write_en, read_en}) <= 1), 64'd1);
      if (gnt != 2'b00) begin
        check("rr_gnt", {62'b0, gnt}, {62'b0, port_mask(nexp)});
        sb.push_back('{port: nexp, err: 1'b0,
                       rdata: nexp ? 32'h0F0F_0F0F : 32'hA5A5_A5A5});
        nexp = ~nexp;
        ng++;
        if (ng == 8) req = 2'b00;
      end
    end
    check("rr_grant_count", 64'(ng), 64'd8);
    repeat (3) @(negedge clk);

`ifdef PERIPH_ARB_LOCK_EN
    // Requester 0 locks across read/write of addr 1; requester 1 must wait.
    do_reset();
    lock[0] = 1'b1;
    drive_cmd(1'b0, 1'b0, 3'd1, 32'h0);
    drive_cmd(1'b1, 1'b0, 3'd3, 32'h0);
    sb.push_back('{port: 1'b0, err: 1'b0, rdata: 32'hA5A5_A5A5});
    wait_gnt(cyc);
    check("lock_gnt_rd", {62'b0, gnt}, 64'h1);
    drive_cmd(1'b0, 1'b1, 3'd1, 32'hCAFE_0001);
    sb.push_back('{port: 1'b0, err: 1'b0, rdata: 32'h0});
    wait_gnt(cyc);
    check("lock_gnt_wr", {62'b0, gnt}, 64'h1);
    check("lock_wr_en", {59'b0, write_en}, 64'h2);
    req[0]  = 1'b0;
    lock[0] = 1'b0;
    sb.push_back('{port: 1'b1, err: 1'b0, rdata: 32'h0F0F_0F0F});
    wait_gnt(cyc);
    check("lock_release_gnt", {62'b0, gnt}, 64'h2);
    req = 2'b00;
    repeat (3) @(negedge clk);
`endif

    repeat (4) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
